mux_4to1: RTL and testbench

//  - Datapath 4:1 selector for the CPU: routes one of four WIDTH-bit operands (register file,

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/mux_4to1_comb.sv | 33 +++
 rtl/mux_4to1.sv | 91 +++++++++
 tb/tb_mux_4to1.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU datapath definitions.
//
// Contents:
//   DATA_W          default datapath width
//   SEL_IN0..3      operand select codes driven onto the shared bus mux
//   src_e           operand-source enum, encoded with the select codes
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] SEL_IN0 = 2'd0;
    localparam logic [1:0] SEL_IN1 = 2'd1;
    localparam logic [1:0] SEL_IN2 = 2'd2;
    localparam logic [1:0] SEL_IN3 = 2'd3;

    // The enum values are tied to the select codes so that a source name
    // can be used directly wherever a select value is expected.
    typedef enum logic [1:0] {
        SRC_REGFILE = SEL_IN0,
        SRC_IMM     = SEL_IN1,
        SRC_ALU     = SEL_IN2,
        SRC_MEM     = SEL_IN3
    } src_e;

endpackage

// File: rtl/mux_4to1_comb.sv
// ---------------------------------------------------------------------------
// mux_4to1_comb
// Pure combinational 4:1 operand selector.
//
// Ports:
//   in0..in3   WIDTH-bit operands (regfile, immediate, ALU, memory)
//   select     2-bit operand index
//   mux_d      selected operand, bit-exact copy of in[select]
// ---------------------------------------------------------------------------
module mux_4to1_comb
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] mux_d
);

    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_high;

    // A ternary tree rather than a case statement: an unknown select bit
    // makes the result unknown wherever the candidates differ, so a bad
    // select is visible in simulation instead of silently picking a leg.
    assign w_low  = select[0] ? in1 : in0;
    assign w_high = select[0] ? in3 : in2;
    assign mux_d  = select[1] ? w_high : w_low;

endmodule

// File: rtl/mux_4to1.sv
// ---------------------------------------------------------------------------
// mux_4to1
// Datapath 4:1 selector onto the shared bus feeding the next pipeline stage.
// With REG_OUT=1 the result is registered (one cycle latency) together with
// a valid qualifier and the select code that produced it; with REG_OUT=0 the
// block is purely combinational and clk/rst_n/hold are ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in0..in3   WIDTH-bit operands
//   select     operand index
//   in_valid   inputs/select are meaningful this cycle
//   hold       freeze all output registers
//   out        selected operand
//   out_valid  out carries a valid selection
//   sel_q      select value that produced the current out
// ---------------------------------------------------------------------------
module mux_4to1
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       select,
    input  logic             in_valid,
    input  logic             hold,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       sel_q
);

    logic [WIDTH-1:0] w_mux_d;

    mux_4to1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .select (select),
        .mux_d  (w_mux_d)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] r_out;
            logic             r_out_valid;
            logic [1:0]       r_sel_q;

            // Reset beats hold, hold beats new data. When the stage is not
            // held and nothing valid arrives, only the valid flag drops; the
            // last data and its select code stay on the bus.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out       <= '0;
                    r_out_valid <= 1'b0;
                    r_sel_q     <= SEL_IN0;
                end else if (!hold) begin
                    if (in_valid) begin
                        r_out       <= w_mux_d;
                        r_out_valid <= 1'b1;
                        r_sel_q     <= select;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
            end

            assign out       = r_out;
            assign out_valid = r_out_valid;
            assign sel_q     = r_sel_q;
        end else begin : g_comb
            // Clock, reset and hold have no role in the combinational build.
            logic w_unused;
            assign w_unused  = clk ^ rst_n ^ hold;

            assign out       = w_mux_d;
            assign out_valid = in_valid;
            assign sel_q     = select;
        end
    endgenerate

endmodule

// File: tb/tb_mux_4to1.sv
// ---------------------------------------------------------------------------
// tb_mux_4to1
// Directed bench for mux_4to1: a registered instance (REG_OUT=1) exercised
// cycle by cycle, and a combinational instance (REG_OUT=0) exercised with
// time delays only. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_mux_4to1;

    logic        clk;
    logic        rst_n;
    logic [15:0] in0, in1, in2, in3;
    logic [1:0]  select;
    logic        in_valid;
    logic        hold;
    logic [15:0] out;
    logic        out_valid;
    logic [1:0]  sel_q;

    logic [15:0] cIn0, cIn1, cIn2, cIn3;
    logic [1:0]  cSelect;
    logic        cInValid;
    logic [15:0] cOut;
    logic        cOutValid;
    logic [1:0]  cSelQ;

    int total = 0;
    int bad   = 0;

    mux_4to1 #(
        .WIDTH   (16),
        .REG_OUT (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .select    (select),
        .in_valid  (in_valid),
        .hold      (hold),
        .out       (out),
        .out_valid (out_valid),
        .sel_q     (sel_q)
    );

    mux_4to1 #(
        .WIDTH   (16),
        .REG_OUT (1'b0)
    ) dutComb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (cIn0),
        .in1       (cIn1),
        .in2       (cIn2),
        .in3       (cIn3),
        .select    (cSelect),
        .in_valid  (cInValid),
        .hold      (hold),
        .out       (cOut),
        .out_valid (cOutValid),
        .sel_q     (cSelQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the registered instance's inputs; called #1 after a rising edge
    // so everything is stable well before the next edge.
    task automatic applyStimulus(input logic rstN, input logic [15:0] a0,
                                 input logic [15:0] a1, input logic [15:0] a2,
                                 input logic [15:0] a3, input logic [1:0] sel,
                                 input logic vld, input logic hld);
        rst_n    = rstN;
        in0      = a0;
        in1      = a1;
        in2      = a2;
        in3      = a3;
        select   = sel;
        in_valid = vld;
        hold     = hld;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [15:0] gotOut, input logic gotValid,
                               input logic [1:0] gotSel,
                               input logic [15:0] expOut, input logic expValid,
                               input logic [1:0] expSel);
        total++;
        assert (gotOut === expOut) else begin
            bad++;
            $error("[TB] FAIL %s out: got=%h expected=%h", tag, gotOut, expOut);
        end
        total++;
        assert (gotValid === expValid) else begin
            bad++;
            $error("[TB] FAIL %s out_valid: got=%b expected=%b", tag, gotValid, expValid);
        end
        total++;
        assert (gotSel === expSel) else begin
            bad++;
            $error("[TB] FAIL %s sel_q: got=%0d expected=%0d", tag, gotSel, expSel);
        end
    endtask

    initial begin
        cIn0 = 16'h0; cIn1 = 16'h0; cIn2 = 16'h0; cIn3 = 16'h0;
        cSelect = 2'd0; cInValid = 1'b0;

        // Reset for two cycles with arbitrary inputs present.
        applyStimulus(1'b0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 2'd2, 1'b1, 1'b1);
        stepClock();
        stepClock();
        checkOutput("reset", out, out_valid, sel_q, 16'h0000, 1'b0, 2'd0);

        // Basic select, one code per cycle.
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 2'd0, 1'b1, 1'b0);
        stepClock();
        checkOutput("sel0", out, out_valid, sel_q, 16'd1, 1'b1, 2'd0);
        select = 2'd1;
        stepClock();
        checkOutput("sel1", out, out_valid, sel_q, 16'd2, 1'b1, 2'd1);
        select = 2'd2;
        stepClock();
        checkOutput("sel2", out, out_valid, sel_q, 16'd3, 1'b1, 2'd2);
        select = 2'd3;
        stepClock();
        checkOutput("sel3", out, out_valid, sel_q, 16'd4, 1'b1, 2'd3);

        // Zero inputs, then data change without select change.
        applyStimulus(1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0, 1'b1, 1'b0);
        stepClock();
        checkOutput("zero", out, out_valid, sel_q, 16'd0, 1'b1, 2'd0);
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 2'd0, 1'b1, 1'b0);
        stepClock();
        checkOutput("zeroThenOne", out, out_valid, sel_q, 16'd1, 1'b1, 2'd0);

        // Hold freezes all outputs across two edges.
        select = 2'd2;
        stepClock();
        checkOutput("preHold", out, out_valid, sel_q, 16'd3, 1'b1, 2'd2);
        applyStimulus(1'b1, 16'd1, 16'd2, 16'hFFFF, 16'd4, 2'd3, 1'b1, 1'b1);
        stepClock();
        checkOutput("hold1", out, out_valid, sel_q, 16'd3, 1'b1, 2'd2);
        stepClock();
        checkOutput("hold2", out, out_valid, sel_q, 16'd3, 1'b1, 2'd2);
        hold = 1'b0;
        stepClock();
        checkOutput("release", out, out_valid, sel_q, 16'd4, 1'b1, 2'd3);

        // Valid gating keeps data and sel_q, drops out_valid.
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 2'd1, 1'b0, 1'b0);
        stepClock();
        checkOutput("invalid", out, out_valid, sel_q, 16'd4, 1'b0, 2'd3);
        in_valid = 1'b1;
        stepClock();
        checkOutput("revalid", out, out_valid, sel_q, 16'd2, 1'b1, 2'd1);

        // Hold also keeps out_valid low when it was low.
        in_valid = 1'b0;
        stepClock();
        checkOutput("invalid2", out, out_valid, sel_q, 16'd2, 1'b0, 2'd1);
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 2'd3, 1'b1, 1'b1);
        stepClock();
        checkOutput("holdInvalid", out, out_valid, sel_q, 16'd2, 1'b0, 2'd1);

        // Input data tracked with select unchanged.
        applyStimulus(1'b1, 16'd1, 16'h1234, 16'd3, 16'd4, 2'd1, 1'b1, 1'b0);
        stepClock();
        checkOutput("track", out, out_valid, sel_q, 16'h1234, 1'b1, 2'd1);

        // Reset mid-stream overrides hold; recovery waits for in_valid.
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'hA5A5, 2'd3, 1'b1, 1'b0);
        stepClock();
        checkOutput("preReset", out, out_valid, sel_q, 16'hA5A5, 1'b1, 2'd3);
        rst_n = 1'b0;
        hold  = 1'b1;
        stepClock();
        checkOutput("midReset", out, out_valid, sel_q, 16'h0000, 1'b0, 2'd0);
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'hA5A5, 2'd3, 1'b0, 1'b0);
        stepClock();
        checkOutput("postResetIdle", out, out_valid, sel_q, 16'h0000, 1'b0, 2'd0);
        in_valid = 1'b1;
        stepClock();
        checkOutput("postResetFirst", out, out_valid, sel_q, 16'hA5A5, 1'b1, 2'd3);

        // Combinational build: changes propagate with only time passing.
        #2;
        cIn0 = 16'h0011; cIn1 = 16'h0022; cIn2 = 16'h0033; cIn3 = 16'hA5A5;
        cSelect = 2'd3; cInValid = 1'b1;
        #1;
        checkOutput("combSel3", cOut, cOutValid, cSelQ, 16'hA5A5, 1'b1, 2'd3);
        cSelect = 2'd0;
        #1;
        checkOutput("combSel0", cOut, cOutValid, cSelQ, 16'h0011, 1'b1, 2'd0);
        cIn0 = 16'h5A5A;
        cInValid = 1'b0;
        #1;
        checkOutput("combData", cOut, cOutValid, cSelQ, 16'h5A5A, 1'b0, 2'd0);
        cSelect = 2'd2;
        #1;
        checkOutput("combSel2", cOut, cOutValid, cSelQ, 16'h0033, 1'b0, 2'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
